// File: rtl/sw_input_conditioner.sv
// rtl/sw_input_conditioner.sv - switch synchroniser/debouncer presenting a valid/ack byte per handshake toggle
// Optional debounce filter on the handshake switch: define SW_DEBOUNCE_EN.
module sw_input_conditioner #(
  parameter int N               = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [N-1:0] sw_data_i,
  input  logic         sw_ready_i,
  output logic [N-1:0] in_data_o,
  output logic         in_valid_o,
  input  logic         in_ack_i,
  output logic         overrun_o
);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  logic         rdy_s1_q, rdy_s2_q;
  logic [N-1:0] data_s1_q, data_s2_q;
  logic [1:0]   state_q, state_d;
  logic         init_cnt_q, init_cnt_d;
  logic         stable_lvl_q, stable_lvl_d;
  logic [N-1:0] in_data_q, in_data_d;
  logic         in_valid_q, in_valid_d;
  logic         overrun_q, overrun_d;
  logic         mismatch;
  logic         toggle;

  assign mismatch = (rdy_s2_q != stable_lvl_q);

`ifdef SW_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    toggle   = 1'b0;
    db_cnt_d = '0;
    if (state_q != ST_INIT && mismatch) begin
      if (db_cnt_q == CNT_LAST) begin
        toggle = 1'b1;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
    end
  end
`else
  // Without the filter the count parameter only keeps the interface uniform.
  if (DEBOUNCE_CYCLES < 1) begin : g_cfg_unused
  end

  assign toggle = (state_q != ST_INIT) && mismatch;
`endif

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    stable_lvl_d = stable_lvl_q;
    in_data_d    = in_data_q;
    in_valid_d   = in_valid_q;
    overrun_d    = overrun_q;
    case (state_q)
      ST_INIT: begin
        // Track the level s2 takes on this edge so leaving INIT never sees a mismatch.
        stable_lvl_d = rdy_s1_q;
        init_cnt_d   = 1'b1;
        if (init_cnt_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (toggle) begin
          in_data_d  = data_s2_q;
          in_valid_d = 1'b1;
          state_d    = ST_PEND;
        end
      end
      ST_PEND: begin
        if (toggle && in_ack_i) begin
          in_data_d = data_s2_q;
        end else if (toggle) begin
          overrun_d = 1'b1;
        end else if (in_ack_i) begin
          in_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
    if (toggle) begin
      stable_lvl_d = rdy_s2_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdy_s1_q     <= 1'b0;
      rdy_s2_q     <= 1'b0;
      data_s1_q    <= '0;
      data_s2_q    <= '0;
      state_q      <= ST_INIT;
      init_cnt_q   <= 1'b0;
      stable_lvl_q <= 1'b0;
      in_data_q    <= '0;
      in_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rdy_s1_q     <= sw_ready_i;
      rdy_s2_q     <= rdy_s1_q;
      data_s1_q    <= sw_data_i;
      data_s2_q    <= data_s1_q;
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      stable_lvl_q <= stable_lvl_d;
      in_data_q    <= in_data_d;
      in_valid_q   <= in_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign in_data_o  = in_data_q;
  assign in_valid_o = in_valid_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_sw_input_conditioner.sv
// tb/tb_sw_input_conditioner.sv - scoreboard bench for sw_input_conditioner
module tb_sw_input_conditioner;

  localparam int DC = 4;
`ifdef SW_DEBOUNCE_EN
  localparam int LAT = 1 + DC;
`else
  localparam int LAT = 2;
`endif

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [7:0] sw_data_i;
  logic       sw_ready_i;
  logic [7:0] in_data_o;
  logic       in_valid_o;
  logic       in_ack_i;
  logic       overrun_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  bit prev_valid = 1'b0;
  bit prev_ack   = 1'b0;

  sw_input_conditioner #(.N(8), .DEBOUNCE_CYCLES(DC)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .sw_data_i(sw_data_i), .sw_ready_i(sw_ready_i),
    .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ack_i(in_ack_i), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A new byte is on offer when valid rises, or stays up across an ack cycle.
  always @(negedge clk_i) begin
    if (in_valid_o === 1'b1 && (!prev_valid || prev_ack)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_txn: got %0h expected none", in_data_o);
      end else begin
        chk("capture_data", in_data_o, exp_q.pop_front());
      end
    end
    prev_valid = (in_valid_o === 1'b1);
    prev_ack   = (in_ack_i === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (in_valid_o !== 1'b1 && lat < 60) begin
      @(negedge clk_i);
      lat++;
    end
  endtask

  task automatic send(input logic [7:0] b);
    int lat;
    sw_data_i = b;
    tick(3);
    exp_q.push_back(b);
    sw_ready_i = ~sw_ready_i;
    wait_valid(lat);
    chk("latency", lat, LAT + 2);
  endtask

  task automatic ack_and_check(input logic [7:0] b);
    tick(1);
    in_ack_i = 1'b1;
    tick(1);
    in_ack_i = 1'b0;
    chk("ack_drops_valid", in_valid_o, 1'b0);
    chk("data_held", in_data_o, b);
  endtask

  initial begin
    logic [7:0] b;
    reset_i = 1'b1; sw_data_i = 8'h00; sw_ready_i = 1'b1; in_ack_i = 1'b0;
    tick(3);
    chk("rst_data", in_data_o, 8'h00);
    chk("rst_valid", in_valid_o, 1'b0);
    chk("rst_overrun", overrun_o, 1'b0);
    reset_i = 1'b0;
    tick(22);
    chk("ready_high_at_release_valid", in_valid_o, 1'b0);
    chk("ready_high_at_release_overrun", overrun_o, 1'b0);

    reset_i = 1'b1; sw_ready_i = 1'b0;
    tick(3);
    reset_i = 1'b0;
    tick(5);

    send(8'h01);
    ack_and_check(8'h01);
    send(8'hD3);
    ack_and_check(8'hD3);

`ifdef SW_DEBOUNCE_EN
    sw_data_i = 8'hA5;
    tick(3);
    sw_ready_i = ~sw_ready_i;
    tick(DC - 1);
    sw_ready_i = ~sw_ready_i;
    tick(12);
    chk("glitch_rejected", in_valid_o, 1'b0);
    send(8'h3C);
    ack_and_check(8'h3C);
`endif

    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        tick(1);
        in_ack_i = 1'b1;
        tick(1);
        in_ack_i = 1'b0;
      end
      tick($urandom_range(0, 4));
      b = 8'($urandom);
      send(b);
      sw_data_i = 8'($urandom);
      tick($urandom_range(0, 5));
      ack_and_check(b);
    end

    send(8'h55);
    sw_data_i = 8'hFE;
    tick(3);
    exp_q.push_back(8'hFE);
    sw_ready_i = ~sw_ready_i;
    tick(LAT);
    in_ack_i = 1'b1;
    tick(1);
    in_ack_i = 1'b0;
    chk("ack_toggle_valid", in_valid_o, 1'b1);
    chk("ack_toggle_data", in_data_o, 8'hFE);
    chk("ack_toggle_overrun", overrun_o, 1'b0);
    ack_and_check(8'hFE);

    send(8'h02);
    sw_data_i = 8'h04;
    tick(3);
    sw_ready_i = ~sw_ready_i;
    tick(LAT + 3);
    chk("overrun_valid", in_valid_o, 1'b1);
    chk("overrun_data", in_data_o, 8'h02);
    chk("overrun_flag", overrun_o, 1'b1);

    reset_i = 1'b1;
    tick(1);
    chk("midpend_rst_data", in_data_o, 8'h00);
    chk("midpend_rst_valid", in_valid_o, 1'b0);
    chk("midpend_rst_overrun", overrun_o, 1'b0);
    reset_i = 1'b0;
    tick(3);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_input_conditioner.md
# sw_input_conditioner

Front-end stage between the board switches and the picoMIPS input port. It synchronises the general-purpose switch byte and the level-toggle handshake switch, and optionally debounces them. On each handshake toggle (either direction) it captures the byte and presents it to the CPU as a valid/ack transaction. It sits directly upstream of the CPU's switch-read path in the top level, replacing raw SW[8:0] wiring.

## Interface
- N, 8: data width (switch byte)
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a handshake level change is accepted (≥1; used only with debounce compiled in)

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- sw_data  in  N  raw switch byte (SW[7:0]), asynchronous to clk
- sw_ready  in  1  raw handshake switch (SW[8]), asynchronous; every level change signals a new byte
- in_data  out  N  captured byte presented to CPU
- in_valid  out  1  in_data holds an unconsumed byte
- in_ack  in  1  one-cycle pulse from CPU: byte consumed
- overrun  out  1  sticky: a toggle arrived while in_valid was high

## Operation
- Synchronisers: sw_ready and sw_data each pass through two flops (s1, s2), reset to 0.
- States: INIT, IDLE, PEND.
- INIT: entered on reset. Held for 2 cycles so the synchronisers settle. Then stable_lvl loads s2(sw_ready); move to IDLE. No toggle is generated, so sw_ready high at reset release yields no transaction.
- Toggle detection, without debounce: toggle = s2(sw_ready) != stable_lvl. On toggle, stable_lvl is updated.
- Toggle detection, with debounce: the counter clears whenever s2(sw_ready) == stable_lvl. Otherwise it increments each cycle. When it reaches DEBOUNCE_CYCLES-1 while still mismatched, toggle fires, stable_lvl updates and the counter clears.
- Capture: on toggle, the s2(sw_data) value of that same cycle loads into in_data.
- IDLE + toggle: capture, set in_valid, go to PEND.
- PEND + in_ack, no toggle: clear in_valid, go to IDLE. in_data holds its last value.
- PEND + toggle, no ack: new byte discarded, in_data unchanged, overrun set, stay in PEND.
- PEND + in_ack + toggle in same cycle: capture new byte, in_valid stays 1, stay in PEND, no overrun.
- in_ack in IDLE or INIT is ignored.
- Toggles in INIT are ignored.
- overrun clears only on reset.
- Reset at any time: all registers go to 0, state goes to INIT. Any pending byte is lost.

## Timing
- Reset values: in_data=0, in_valid=0, overrun=0, stable_lvl=0, counter=0, sync flops=0.
- Without debounce, sw_ready changes before clk edge E0:
  - s1 updates at E0, s2 at E1.
  - Toggle is combinational in the cycle after E1.
  - in_valid and in_data are registered high/updated at E2. Latency is 3 edges.
- With debounce: the mismatch must persist for DEBOUNCE_CYCLES consecutive s2 samples. in_valid rises at edge E(1+DEBOUNCE_CYCLES).
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no toggle.
- in_valid drops on the edge that samples in_ack (1-cycle ack latency).
- sw_data must be stable from 2 cycles before the accepted toggle. Stimulus holds data ≥1 µs before changing sw_ready.
- Throughput: at most one byte per toggle. Max one transaction per 2 cycles (capture, ack).

## Configuration
- SW_DEBOUNCE_EN defined: debounce counter instantiated. Width is $clog2(DEBOUNCE_CYCLES)+1; latency as above.
- SW_DEBOUNCE_EN undefined: counter removed. DEBOUNCE_CYCLES is ignored; a toggle fires on the first mismatching s2 sample.

## Test plan
- Reset with sw_ready=1 held: after INIT, in_valid stays 0 for 20 cycles, overrun=0.
- sw_data=0x01, sw_ready 0→1: in_valid=1, in_data=0x01 at the specified latency. in_ack pulse → in_valid=0 next edge.
- Then sw_data=0xD3 (−45), sw_ready 1→0: second transaction in_data=0xD3, confirming the falling edge is a valid toggle.
- SW_DEBOUNCE_EN, DEBOUNCE_CYCLES=4:
  - sw_ready high for 3 cycles, then back to low → no in_valid.
  - Held high for 4 cycles → in_valid=1.
- Two toggles without ack (0x02 then 0x04): in_data=0x02, overrun=1, in_valid=1.
- in_ack and an accepted toggle (0xFE) in the same cycle: in_valid stays 1, in_data=0xFE, overrun=0. Then assert reset mid-PEND → all outputs 0 the next edge.
